operand_fetch_unit: RTL and testbench
=====================================

Name: operand_fetch_unit

Overview:
- Reader side of the register file read ports for a single execution pipe.
- Accepts decoded instructions from the decoder over a valid/ready handshake and checks RAW and WAW hazards against a busy-register scoreboard.
- Drives the register file primary and secondary read ports, captures the returned operands one cycle later, and presents complete operand packets to the execution unit through a small FIFO with valid/ready backpressure.

Parameters:
- NUM_REGS, 32, number of architectural registers tracked by the scoreboard; addresses are 5 bits.
- BUF_DEPTH, 2, depth of the operand output FIFO (power of 2, ≥2).

Ports:
- clock_i  in  1  clock; all logic is on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- dec_valid_i  in  1  decoder has an instruction.
- dec_ready_o  out  1  instruction accepted this edge when high together with dec_valid_i.
- dec_opcode_i  in  8  opcode, passed through unchanged.
- dec_dest_i  in  5  destination register.
- dec_writes_dest_i  in  1  instruction writes dec_dest_i.
- dec_src1_i  in  5  source 1 register, or 5-bit immediate.
- dec_src1_is_reg_i  in  1  source 1 is a register.
- dec_src2_i  in  16  source 2 register (low 5 bits), or 16-bit immediate.
- dec_src2_is_reg_i  in  1  source 2 is a register.
- rf_read_primary_o  out  1  register file primary read enable.
- rf_read_secondary_o  out  1  register file secondary read enable.
- rf_addr1_o  out  5  register file primary address / immediate.
- rf_addr2_o  out  16  register file secondary address / immediate.
- rf_data1_i  in  16  register file primary data, registered, valid the cycle after the read.
- rf_data2_i  in  16  register file secondary data, same timing as rf_data1_i.
- rf_status_i  in  2  register file operation status (bit1 overflow, bit0 underflow), same timing.
- wb_enable_i  in  1  writeback to the register file this edge.
- wb_addr_i  in  5  writeback destination.
- ex_valid_o  out  1  operand packet available at the FIFO head.
- ex_ready_i  in  1  execution unit consumes the head this edge.
- ex_opcode_o  out  8  head opcode.
- ex_dest_o  out  5  head destination register.
- ex_writes_dest_o  out  1  head write flag.
- ex_op1_o  out  16  head operand 1.
- ex_op2_o  out  16  head operand 2.
- ex_status_o  out  2  head status snapshot.
- busy_o  out  NUM_REGS  scoreboard, exposed for debug.

Behaviour:
- Reset (reset_i low, asynchronous) clears:
  - scoreboard to 0;
  - the pending flag;
  - the FIFO (count 0, pointers 0).
- While in reset, all outputs read 0, including dec_ready_o and ex_valid_o.
- Hazard is true when any of the following holds. The check uses the registered busy bits only, with no same-cycle writeback bypass, because the register file returns the old value on a same-edge write.
  - dec_src1_is_reg_i and busy[dec_src1_i];
  - dec_src2_is_reg_i and busy[dec_src2_i[4:0]];
  - dec_writes_dest_i and busy[dec_dest_i].
- Occupancy is fifo_count + pending. A pop is ex_valid_o && ex_ready_i.
- dec_ready_o = !hazard && (occupancy < BUF_DEPTH || pop). It is combinational and must not depend on dec_valid_i.
- Accept is dec_valid_i && dec_ready_o.
- RF port drive (combinational):
  - rf_addr1_o = dec_src1_i and rf_addr2_o = dec_src2_i at all times.
  - rf_read_primary_o = accept && dec_src1_is_reg_i.
  - rf_read_secondary_o = accept && dec_src2_is_reg_i.
  - An immediate source leaves its enable low, so the register file passes the immediate through; src1 is zero-extended to 16 bits.
- Accept edge E0:
  - pending <= 1;
  - opcode, dest and writes_dest are latched into a side register;
  - if dec_writes_dest_i, busy[dec_dest_i] <= 1.
- Edge E1 (pending = 1): {side regs, rf_data1_i, rf_data2_i, rf_status_i} is pushed into the FIFO. pending <= accept (back-to-back accepts are allowed, giving one instruction per cycle).
- The FIFO head is visible after E1, so ex_valid_o rises 2 edges after accept.
- ex_status_o carries rf_status_i only when source 1 was a register read; otherwise it is 0.
- Writeback: wb_enable_i clears busy[wb_addr_i] at the edge. If a set and a clear target the same register on the same edge, the set wins (this cannot occur legally because of the WAW stall, but must be deterministic).
- FIFO push and pop on the same edge keep the count unchanged. The head updates to the next entry, or to the pushed entry if the FIFO held one.
- Overflow is impossible by construction. An assertion flags a push while full.
- ex outputs hold stable while ex_valid_o && !ex_ready_i.
- Reset asserted mid-operation discards the pending read and all FIFO entries, and clears the scoreboard.

Test Plan:
- Reset, then accept {dest=3, writes, src1=r1 reg, src2=imm 0x1234}, with the RF returning r1=0x00AA one cycle later -> rf_read_primary_o=1 and rf_read_secondary_o=0 on the accept edge; ex_valid_o high 2 edges later with op1=0x00AA, op2=0x1234, dest=3; busy_o[3]=1.
- RAW: with r3 busy, offer src1=r3 -> dec_ready_o=0. Pulse wb_enable_i with wb_addr_i=3 -> dec_ready_o=1 in the cycle after that edge, not the same cycle.
- WAW: with r5 busy, offer dest=r5 with writes=1 -> stall until writeback of r5; offering dest=r5 with writes=0 and non-busy sources -> accepted immediately.
- Backpressure: hold ex_ready_i=0 and stream 4 independent instructions -> exactly 2 accepted (BUF_DEPTH) and dec_ready_o=0 thereafter. Raise ex_ready_i -> one packet retires per cycle in order, and the remaining 2 instructions are accepted with no loss or duplication.
- Immediate-only instruction src1=imm 0x1F, src2=imm 0xBEEF -> both RF enables low; packet op1=0x001F, op2=0xBEEF, status=0.
- Drop reset_i low with pending=1 and FIFO holding 1 entry -> ex_valid_o=0 and busy_o=0 immediately; after release, the next accepted instruction appears exactly 2 edges later.

Source files
------------

// File: rtl/operand_fetch_unit.sv
// Operand fetch stage: checks decoded instructions against the busy-register scoreboard,
// drives the register file read ports and queues complete operand packets for execution.
module operand_fetch_unit #(
    parameter int NUM_REGS  = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                dec_valid_i,
    output logic                dec_ready_o,
    input  logic [7:0]          dec_opcode_i,
    input  logic [4:0]          dec_dest_i,
    input  logic                dec_writes_dest_i,
    input  logic [4:0]          dec_src1_i,
    input  logic                dec_src1_is_reg_i,
    input  logic [15:0]         dec_src2_i,
    input  logic                dec_src2_is_reg_i,
    output logic                rf_read_primary_o,
    output logic                rf_read_secondary_o,
    output logic [4:0]          rf_addr1_o,
    output logic [15:0]         rf_addr2_o,
    input  logic [15:0]         rf_data1_i,
    input  logic [15:0]         rf_data2_i,
    input  logic [1:0]          rf_status_i,
    input  logic                wb_enable_i,
    input  logic [4:0]          wb_addr_i,
    output logic                ex_valid_o,
    input  logic                ex_ready_i,
    output logic [7:0]          ex_opcode_o,
    output logic [4:0]          ex_dest_o,
    output logic                ex_writes_dest_o,
    output logic [15:0]         ex_op1_o,
    output logic [15:0]         ex_op2_o,
    output logic [1:0]          ex_status_o,
    output logic [NUM_REGS-1:0] busy_o
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(BUF_DEPTH);

    typedef struct packed {
        logic [7:0]  opcode;
        logic [4:0]  dest;
        logic        writes_dest;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [1:0]  status;
    } packet_t;

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic                pending;
    logic [7:0]          side_opcode;
    logic [4:0]          side_dest;
    logic                side_writes;
    logic                side_src1_reg;
    packet_t             mem [BUF_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W:0]      occupancy;
    logic                hazard;
    logic                fifo_valid;
    logic                pop;
    logic                push;
    logic                ready;
    logic                accept;
    packet_t             head;
    packet_t             push_pkt;

    // Registered busy bits only: the RF returns the old value on a same-edge write.
    always_comb begin
        hazard = 1'b0;
        if (dec_src1_is_reg_i && busy[dec_src1_i])      hazard = 1'b1;
        if (dec_src2_is_reg_i && busy[dec_src2_i[4:0]]) hazard = 1'b1;
        if (dec_writes_dest_i && busy[dec_dest_i])      hazard = 1'b1;
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (accept && dec_writes_dest_i) set_vec[dec_dest_i] = 1'b1;
        if (wb_enable_i)                 clr_vec[wb_addr_i]  = 1'b1;
    end

    assign fifo_valid = (count != '0);
    assign pop        = reset_i && fifo_valid && ex_ready_i;
    assign push       = pending;
    // The in-flight read counts against capacity so its push always has a slot.
    assign occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, pending};
    assign ready      = reset_i && !hazard && ((occupancy < DEPTH_OCC) || pop);
    assign accept     = dec_valid_i && ready;

    assign push_pkt = '{opcode:      side_opcode,
                        dest:        side_dest,
                        writes_dest: side_writes,
                        op1:         rf_data1_i,
                        op2:         rf_data2_i,
                        status:      side_src1_reg ? rf_status_i : 2'b00};
    assign head = mem[rd_ptr];

    assign dec_ready_o         = ready;
    assign rf_read_primary_o   = accept && dec_src1_is_reg_i;
    assign rf_read_secondary_o = accept && dec_src2_is_reg_i;
    assign rf_addr1_o          = reset_i ? dec_src1_i : 5'd0;
    assign rf_addr2_o          = reset_i ? dec_src2_i : 16'd0;
    assign ex_valid_o          = reset_i && fifo_valid;
    assign ex_opcode_o         = reset_i ? head.opcode      : 8'd0;
    assign ex_dest_o           = reset_i ? head.dest        : 5'd0;
    assign ex_writes_dest_o    = reset_i && head.writes_dest;
    assign ex_op1_o            = reset_i ? head.op1         : 16'd0;
    assign ex_op2_o            = reset_i ? head.op2         : 16'd0;
    assign ex_status_o         = reset_i ? head.status      : 2'd0;
    assign busy_o              = busy;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            busy          <= '0;
            pending       <= 1'b0;
            side_opcode   <= '0;
            side_dest     <= '0;
            side_writes   <= 1'b0;
            side_src1_reg <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else begin
            // Set after clear so a same-register collision leaves the bit set.
            busy    <= (busy & ~clr_vec) | set_vec;
            pending <= accept;
            if (accept) begin
                side_opcode   <= dec_opcode_i;
                side_dest     <= dec_dest_i;
                side_writes   <= dec_writes_dest_i;
                side_src1_reg <= dec_src1_is_reg_i;
            end
            if (push) begin
                mem[wr_ptr] <= push_pkt;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    overflow_check: assert property (@(posedge clock_i) disable iff (!reset_i)
                                      !(push && (count == FULL_CNT) && !pop));

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Bench for operand_fetch_unit: directed scenarios plus random traffic, checked against
// a queue-based reference model and a behavioural register file.
module tb_operand_fetch_unit;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        dec_valid_i;
    logic        dec_ready_o;
    logic [7:0]  dec_opcode_i;
    logic [4:0]  dec_dest_i;
    logic        dec_writes_dest_i;
    logic [4:0]  dec_src1_i;
    logic        dec_src1_is_reg_i;
    logic [15:0] dec_src2_i;
    logic        dec_src2_is_reg_i;
    logic        rf_read_primary_o;
    logic        rf_read_secondary_o;
    logic [4:0]  rf_addr1_o;
    logic [15:0] rf_addr2_o;
    logic [15:0] rf_data1_i = '0;
    logic [15:0] rf_data2_i = '0;
    logic [1:0]  rf_status_i = '0;
    logic        wb_enable_i;
    logic [4:0]  wb_addr_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [7:0]  ex_opcode_o;
    logic [4:0]  ex_dest_o;
    logic        ex_writes_dest_o;
    logic [15:0] ex_op1_o;
    logic [15:0] ex_op2_o;
    logic [1:0]  ex_status_o;
    logic [31:0] busy_o;

    operand_fetch_unit #(.NUM_REGS(32), .BUF_DEPTH(2)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
        .dec_opcode_i(dec_opcode_i), .dec_dest_i(dec_dest_i),
        .dec_writes_dest_i(dec_writes_dest_i),
        .dec_src1_i(dec_src1_i), .dec_src1_is_reg_i(dec_src1_is_reg_i),
        .dec_src2_i(dec_src2_i), .dec_src2_is_reg_i(dec_src2_is_reg_i),
        .rf_read_primary_o(rf_read_primary_o), .rf_read_secondary_o(rf_read_secondary_o),
        .rf_addr1_o(rf_addr1_o), .rf_addr2_o(rf_addr2_o),
        .rf_data1_i(rf_data1_i), .rf_data2_i(rf_data2_i), .rf_status_i(rf_status_i),
        .wb_enable_i(wb_enable_i), .wb_addr_i(wb_addr_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_opcode_o(ex_opcode_o), .ex_dest_o(ex_dest_o),
        .ex_writes_dest_o(ex_writes_dest_o),
        .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o), .ex_status_o(ex_status_o),
        .busy_o(busy_o)
    );

    // ---------------- clock ----------------
    always #5 clock_i = ~clock_i;

    // ---------------- counters ----------------
    int n_cmp = 0;
    int n_err = 0;

    // ---------------- behavioural register file ----------------
    logic [15:0] regs     [32];
    logic [1:0]  stat_tab [32];

    always @(posedge clock_i) begin
        rf_data1_i  <= rf_read_primary_o   ? regs[rf_addr1_o] : {11'd0, rf_addr1_o};
        rf_data2_i  <= rf_read_secondary_o ? regs[rf_addr2_o[4:0]] : rf_addr2_o;
        rf_status_i <= rf_read_primary_o   ? stat_tab[rf_addr1_o] : 2'($urandom_range(1, 3));
    end

    // ---------------- reference model ----------------
    // Each accepted instruction becomes one expected packet, visible two edges after accept.
    logic [47:0] exp_q[$];
    int          acc_q[$];
    logic [31:0] busy_m = '0;
    int          cyc = 0;

    function automatic logic exp_valid_f();
        return (exp_q.size() > 0) && ((cyc - acc_q[0]) >= 2);
    endfunction

    function automatic logic exp_ready_f();
        logic hz;
        hz = (dec_src1_is_reg_i && busy_m[dec_src1_i]) ||
             (dec_src2_is_reg_i && busy_m[dec_src2_i[4:0]]) ||
             (dec_writes_dest_i && busy_m[dec_dest_i]);
        return reset_i && !hz && ((exp_q.size() < 2) || (exp_valid_f() && ex_ready_i));
    endfunction

    always @(posedge clock_i) begin
        if (!reset_i) begin
            exp_q.delete();
            acc_q.delete();
            busy_m = '0;
        end else begin
            logic        v_now;
            logic        acc;
            logic [15:0] op1;
            logic [15:0] op2;
            logic [1:0]  st;
            v_now = exp_valid_f();
            acc   = dec_valid_i && exp_ready_f();
            op1   = dec_src1_is_reg_i ? regs[dec_src1_i] : {11'd0, dec_src1_i};
            op2   = dec_src2_is_reg_i ? regs[dec_src2_i[4:0]] : dec_src2_i;
            st    = dec_src1_is_reg_i ? stat_tab[dec_src1_i] : 2'b00;
            if (v_now && ex_ready_i) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
            end
            if (acc) begin
                exp_q.push_back({dec_opcode_i, dec_dest_i, dec_writes_dest_i, op1, op2, st});
                acc_q.push_back(cyc);
            end
            if (wb_enable_i) busy_m[wb_addr_i] = 1'b0;
            if (acc && dec_writes_dest_i) busy_m[dec_dest_i] = 1'b1;
        end
        cyc++;
    end

    // ---------------- scoreboard (every falling edge) ----------------
    wire [104:0] all_out = {dec_ready_o, rf_read_primary_o, rf_read_secondary_o, rf_addr1_o,
                            rf_addr2_o, ex_valid_o, ex_opcode_o, ex_dest_o, ex_writes_dest_o,
                            ex_op1_o, ex_op2_o, ex_status_o, busy_o};
    wire [47:0]  head_act = {ex_opcode_o, ex_dest_o, ex_writes_dest_o, ex_op1_o, ex_op2_o,
                             ex_status_o};

    always @(negedge clock_i) begin
        if (!reset_i) begin
            n_cmp++;
            if (all_out !== '0) begin
                n_err++;
                $display("FAIL sb_reset_outputs: got %h want 0", all_out);
            end
        end else begin
            logic er;
            logic [1:0] en_exp;
            er     = exp_ready_f();
            en_exp = {dec_valid_i && er && dec_src1_is_reg_i, dec_valid_i && er && dec_src2_is_reg_i};
            n_cmp++;
            if (dec_ready_o !== er) begin
                n_err++;
                $display("FAIL sb_dec_ready: got %b want %b (cyc %0d)", dec_ready_o, er, cyc);
            end
            n_cmp++;
            if ({rf_read_primary_o, rf_read_secondary_o} !== en_exp) begin
                n_err++;
                $display("FAIL sb_rf_enables: got %b want %b", {rf_read_primary_o, rf_read_secondary_o}, en_exp);
            end
            n_cmp++;
            if ({rf_addr1_o, rf_addr2_o} !== {dec_src1_i, dec_src2_i}) begin
                n_err++;
                $display("FAIL sb_rf_addr: got %h want %h", {rf_addr1_o, rf_addr2_o}, {dec_src1_i, dec_src2_i});
            end
            n_cmp++;
            if (ex_valid_o !== exp_valid_f()) begin
                n_err++;
                $display("FAIL sb_ex_valid: got %b want %b (cyc %0d)", ex_valid_o, exp_valid_f(), cyc);
            end
            if (exp_valid_f()) begin
                n_cmp++;
                if (head_act !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL sb_packet: got %h want %h", head_act, exp_q[0]);
                end
            end
            n_cmp++;
            if (busy_o !== busy_m) begin
                n_err++;
                $display("FAIL sb_busy: got %h want %h", busy_o, busy_m);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clock_i);
    endtask

    task automatic idle();
        dec_valid_i = 1'b0;
        wb_enable_i = 1'b0;
    endtask

    task automatic offer(input logic [7:0] op, input logic [4:0] d, input logic w,
                         input logic [4:0] s1, input logic s1r,
                         input logic [15:0] s2, input logic s2r);
        dec_valid_i       = 1'b1;
        dec_opcode_i      = op;
        dec_dest_i        = d;
        dec_writes_dest_i = w;
        dec_src1_i        = s1;
        dec_src1_is_reg_i = s1r;
        dec_src2_i        = s2;
        dec_src2_is_reg_i = s2r;
    endtask

    task automatic wb_clear(input logic [4:0] a);
        wb_enable_i = 1'b1;
        wb_addr_i   = a;
        step();
        wb_enable_i = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        dec_valid_i = 1'b1;
        dec_src1_i  = 5'h15;
        dec_src2_i  = 16'hABCD;
        step();
        step();
        to_neg();
        n_cmp++;
        if (all_out !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        step();
        reset_i = 1'b1;
        idle();
        dec_src1_i = '0;
        dec_src2_i = '0;
        to_neg();
        n_cmp++;
        if ({dec_ready_o, ex_valid_o, busy_o} !== {1'b1, 1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_release: got %b/%b/%h want 1/0/0", dec_ready_o, ex_valid_o, busy_o);
        end
        step();
    endtask

    task automatic test_basic();
        ex_ready_i = 1'b0;
        offer(8'h11, 5'd3, 1'b1, 5'd1, 1'b1, 16'h1234, 1'b0);
        to_neg();
        n_cmp++;
        if ({dec_ready_o, rf_read_primary_o, rf_read_secondary_o} !== 3'b110) begin
            n_err++;
            $display("FAIL basic_accept_enables: got %b want 110",
                     {dec_ready_o, rf_read_primary_o, rf_read_secondary_o});
        end
        step();
        idle();
        to_neg();
        n_cmp++;
        if ({ex_valid_o, busy_o[3]} !== 2'b01) begin
            n_err++;
            $display("FAIL basic_after_e0: got valid=%b busy3=%b want 0/1", ex_valid_o, busy_o[3]);
        end
        step();
        to_neg();
        n_cmp++;
        if ({ex_valid_o, ex_op1_o, ex_op2_o, ex_dest_o, ex_opcode_o} !==
            {1'b1, 16'h00AA, 16'h1234, 5'd3, 8'h11}) begin
            n_err++;
            $display("FAIL basic_packet: got v=%b op1=%h op2=%h dest=%0d opc=%h want 1/00aa/1234/3/11",
                     ex_valid_o, ex_op1_o, ex_op2_o, ex_dest_o, ex_opcode_o);
        end
        step();
        ex_ready_i = 1'b1;
        step();
        ex_ready_i = 1'b0;
    endtask

    task automatic test_raw();
        ex_ready_i = 1'b1;
        offer(8'h22, 5'd7, 1'b0, 5'd3, 1'b1, 16'h0000, 1'b0);
        to_neg();
        n_cmp++;
        if (dec_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL raw_stall: got %b want 0", dec_ready_o);
        end
        step();
        wb_enable_i = 1'b1;
        wb_addr_i   = 5'd3;
        to_neg();
        n_cmp++;
        if (dec_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL raw_no_bypass: got %b want 0", dec_ready_o);
        end
        step();
        wb_enable_i = 1'b0;
        to_neg();
        n_cmp++;
        if (dec_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL raw_release: got %b want 1", dec_ready_o);
        end
        step();
        idle();
        step();
        step();
    endtask

    task automatic test_waw();
        ex_ready_i = 1'b1;
        offer(8'h33, 5'd5, 1'b1, 5'd2, 1'b0, 16'h0009, 1'b0);
        step();
        offer(8'h34, 5'd5, 1'b1, 5'd4, 1'b0, 16'h0007, 1'b0);
        for (int i = 0; i < 3; i++) begin
            to_neg();
            n_cmp++;
            if (dec_ready_o !== 1'b0) begin
                n_err++;
                $display("FAIL waw_stall_%0d: got %b want 0", i, dec_ready_o);
            end
            step();
        end
        offer(8'h35, 5'd5, 1'b0, 5'd4, 1'b0, 16'h0007, 1'b0);
        to_neg();
        n_cmp++;
        if (dec_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL waw_nowrite_accept: got %b want 1", dec_ready_o);
        end
        step();
        offer(8'h36, 5'd5, 1'b1, 5'd4, 1'b0, 16'h0007, 1'b0);
        wb_enable_i = 1'b1;
        wb_addr_i   = 5'd5;
        step();
        wb_enable_i = 1'b0;
        to_neg();
        n_cmp++;
        if (dec_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL waw_release: got %b want 1", dec_ready_o);
        end
        step();
        idle();
        wb_clear(5'd5);
        step();
        step();
    endtask

    task automatic test_backpressure();
        int idx;
        int pops;
        int first_pop;
        int last_pop;
        logic took;
        logic popped;
        idx       = 0;
        pops      = 0;
        first_pop = -1;
        last_pop  = -1;
        ex_ready_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            offer(8'h80 + 8'(idx), 5'(10 + idx), 1'b1, 5'(20 + idx), 1'b1, 16'(24 + idx), 1'b1);
            to_neg();
            took = dec_ready_o;
            step();
            if (took) idx++;
        end
        to_neg();
        n_cmp++;
        if (idx !== 2 || dec_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL bp_fill: got accepted=%0d ready=%b want 2/0", idx, dec_ready_o);
        end
        step();
        ex_ready_i = 1'b1;
        for (int c = 0; c < 20 && pops < 4; c++) begin
            if (idx < 4)
                offer(8'h80 + 8'(idx), 5'(10 + idx), 1'b1, 5'(20 + idx), 1'b1, 16'(24 + idx), 1'b1);
            else
                idle();
            to_neg();
            took   = dec_valid_i && dec_ready_o;
            popped = ex_valid_o && ex_ready_i;
            step();
            if (took) idx++;
            if (popped) begin
                pops++;
                if (first_pop < 0) first_pop = c;
                last_pop = c;
            end
        end
        idle();
        n_cmp++;
        if (idx !== 4 || pops !== 4 || (last_pop - first_pop) !== 3) begin
            n_err++;
            $display("FAIL bp_drain: got accepted=%0d pops=%0d span=%0d want 4/4/3",
                     idx, pops, last_pop - first_pop);
        end
        for (int a = 10; a < 14; a++) wb_clear(5'(a));
    endtask

    task automatic test_immediate();
        ex_ready_i = 1'b0;
        offer(8'h44, 5'd9, 1'b0, 5'h1F, 1'b0, 16'hBEEF, 1'b0);
        to_neg();
        n_cmp++;
        if ({dec_ready_o, rf_read_primary_o, rf_read_secondary_o} !== 3'b100) begin
            n_err++;
            $display("FAIL imm_enables: got %b want 100",
                     {dec_ready_o, rf_read_primary_o, rf_read_secondary_o});
        end
        step();
        idle();
        step();
        to_neg();
        n_cmp++;
        if ({ex_valid_o, ex_op1_o, ex_op2_o, ex_status_o} !== {1'b1, 16'h001F, 16'hBEEF, 2'b00}) begin
            n_err++;
            $display("FAIL imm_packet: got v=%b op1=%h op2=%h st=%b want 1/001f/beef/00",
                     ex_valid_o, ex_op1_o, ex_op2_o, ex_status_o);
        end
        step();
        ex_ready_i = 1'b1;
        step();
        ex_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        ex_ready_i = 1'b0;
        offer(8'h55, 5'd14, 1'b1, 5'd1, 1'b1, 16'h0003, 1'b0);
        step();
        offer(8'h66, 5'd15, 1'b1, 5'd2, 1'b1, 16'h0004, 1'b0);
        step();
        idle();
        #1;
        reset_i = 1'b0;
        #1;
        n_cmp++;
        if ({ex_valid_o, dec_ready_o, busy_o} !== {2'b00, 32'd0}) begin
            n_err++;
            $display("FAIL midreset_clear: got v=%b rdy=%b busy=%h want 0/0/0",
                     ex_valid_o, dec_ready_o, busy_o);
        end
        to_neg();
        @(posedge clock_i);
        #3;
        reset_i = 1'b1;
        to_neg();
        step();
        offer(8'h77, 5'd16, 1'b1, 5'd4, 1'b1, 16'h0055, 1'b0);
        to_neg();
        n_cmp++;
        if (dec_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_ready: got %b want 1", dec_ready_o);
        end
        step();
        idle();
        to_neg();
        n_cmp++;
        if (ex_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_early: got %b want 0", ex_valid_o);
        end
        step();
        to_neg();
        n_cmp++;
        if ({ex_valid_o, ex_opcode_o, ex_op1_o} !== {1'b1, 8'h77, regs[4]}) begin
            n_err++;
            $display("FAIL midreset_latency: got v=%b opc=%h op1=%h want 1/77/%h",
                     ex_valid_o, ex_opcode_o, ex_op1_o, regs[4]);
        end
        ex_ready_i = 1'b1;
        step();
        ex_ready_i = 1'b0;
        wb_clear(5'd16);
    endtask

    task automatic test_random();
        logic [15:0] s2;
        logic        s2r;
        for (int c = 0; c < 400; c++) begin
            s2r = 1'($urandom_range(0, 1));
            s2  = 16'($urandom);
            if (s2r) s2[4:0] = 5'($urandom_range(0, 7));
            offer(8'($urandom), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), s2, s2r);
            dec_valid_i = ($urandom_range(0, 3) != 0);
            ex_ready_i  = ($urandom_range(0, 2) != 0);
            wb_enable_i = ($urandom_range(0, 2) == 0);
            wb_addr_i   = 5'($urandom_range(0, 7));
            step();
        end
        idle();
        ex_ready_i = 1'b1;
        for (int a = 0; a < 8; a++) wb_clear(5'(a));
        step();
        to_neg();
        n_cmp++;
        if ({ex_valid_o, busy_o} !== {1'b0, 32'd0} || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL random_drain: got v=%b busy=%h model_left=%0d want 0/0/0",
                     ex_valid_o, busy_o, exp_q.size());
        end
        step();
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        for (int i = 0; i < 32; i++) begin
            regs[i]     = 16'($urandom);
            stat_tab[i] = 2'($urandom);
        end
        regs[1]           = 16'h00AA;
        reset_i           = 1'b0;
        dec_valid_i       = 1'b0;
        dec_opcode_i      = '0;
        dec_dest_i        = '0;
        dec_writes_dest_i = 1'b0;
        dec_src1_i        = '0;
        dec_src1_is_reg_i = 1'b0;
        dec_src2_i        = '0;
        dec_src2_is_reg_i = 1'b0;
        wb_enable_i       = 1'b0;
        wb_addr_i         = '0;
        ex_ready_i        = 1'b0;

        test_reset();
        test_basic();
        test_raw();
        test_waw();
        test_backpressure();
        test_immediate();
        test_reset_mid();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
